// File: rtl/slice_adder_pkg.sv
// ---------------------------------------------------------------------------
// slice_adder_pkg
// Shared constants and helpers for the slice-pipelined adder.
//   WIDTH_DEFAULT : default operand/sum width in bits
//   SLICE_DEFAULT : default number of bits added per pipeline stage
//   stage_count() : number of pipeline stages for a WIDTH/SLICE pair
// ---------------------------------------------------------------------------
package slice_adder_pkg;

  localparam int unsigned WIDTH_DEFAULT = 32'd16;
  localparam int unsigned SLICE_DEFAULT = 32'd4;

  // One stage per slice of the operand.
  function automatic int unsigned stage_count(input int unsigned width,
                                              input int unsigned slice);
    return width / slice;
  endfunction

endpackage

// File: rtl/slice_add_stage.sv
// ---------------------------------------------------------------------------
// slice_add_stage
// One pipeline stage of the slice adder: adds slice IDX of the operands with
// the carry registered by the previous stage and registers the outcome.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : global advance; when low every register holds
//   valid_i    : upstream stage holds a live operation
//   carry_i    : carry into this slice
//   acc_i      : completed lower sum slices + unconsumed upper A slices
//   b_i        : (possibly inverted) B operand
//   valid_o    : registered valid bit
//   carry_o    : registered carry out of this slice
//   ovf_o      : registered signed overflow of this slice's top bit
//                (only meaningful on the last stage)
//   acc_o      : acc with slice IDX replaced by its sum
//   b_o        : B operand carried forward
// ---------------------------------------------------------------------------
module slice_add_stage
  import slice_adder_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned SLICE = SLICE_DEFAULT,
  parameter int unsigned IDX   = 32'd0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             valid_i,
  input  logic             carry_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             valid_o,
  output logic             carry_o,
  output logic             ovf_o,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] b_o
);

  localparam int unsigned LO = IDX * SLICE;
  localparam int unsigned HI = LO + SLICE - 32'd1;

  logic [SLICE:0]   slice_sum_s;
  logic             valid_d, valid_q;
  logic             carry_d, carry_q;
  logic             ovf_d,   ovf_q;
  logic [WIDTH-1:0] acc_d,   acc_q;
  logic [WIDTH-1:0] b_d,     b_q;

  // Slice addition and next-state selection (hold when not advancing).
  always_comb begin
    slice_sum_s = {1'b0, acc_i[HI:LO]} + {1'b0, b_i[HI:LO]}
                + {{SLICE{1'b0}}, carry_i};
    valid_d = valid_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    acc_d   = acc_q;
    b_d     = b_q;
    if (en) begin
      valid_d = valid_i;
      carry_d = slice_sum_s[SLICE];
      // Carry into the slice's top bit is a^b^s there; overflow is that
      // carry differing from the carry out.
      ovf_d   = acc_i[HI] ^ b_i[HI] ^ slice_sum_s[SLICE-1] ^ slice_sum_s[SLICE];
      acc_d   = acc_i;
      acc_d[HI:LO] = slice_sum_s[SLICE-1:0];
      b_d     = b_i;
    end else begin
      valid_d = valid_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;
      acc_d   = acc_q;
      b_d     = b_q;
    end
  end

  // Stage registers; all clear immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      acc_q   <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
    end
  end

  assign valid_o = valid_q;
  assign carry_o = carry_q;
  assign ovf_o   = ovf_q;
  assign acc_o   = acc_q;
  assign b_o     = b_q;

endmodule

// File: rtl/slice_pipe_adder.sv
// ---------------------------------------------------------------------------
// slice_pipe_adder
// WIDTH-bit adder/subtractor pipelined in SLICE-bit stages with a
// valid/ready handshake on both sides. The last stage's registers are the
// result registers.
//   CLK, RST_N          : clock, asynchronous active-low reset
//   IN_VALID / IN_READY : operand handshake (IN_READY = global advance)
//   A, B, C0, SUB       : operands, carry-in, mode (1 = add with B inverted)
//   OUT_VALID/OUT_READY : result handshake
//   S, COUT, OVF        : sum, carry out, signed overflow
// ---------------------------------------------------------------------------
module slice_pipe_adder
  import slice_adder_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned SLICE = SLICE_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C0,
  input  logic             SUB,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] S,
  output logic             COUT,
  output logic             OVF
);

  localparam int unsigned N = stage_count(WIDTH, SLICE);

  if (((WIDTH % SLICE) != 32'd0) || (WIDTH < SLICE)) begin : g_bad_cfg
    $error("slice_pipe_adder: WIDTH must be a non-zero multiple of SLICE");
  end

  // Element k feeds stage k; element k+1 is stage k's registered output.
  logic             valid_c [0:N];
  logic             carry_c [0:N];
  logic             ovf_c   [1:N];
  logic [WIDTH-1:0] acc_c   [0:N];
  logic [WIDTH-1:0] b_c     [0:N];
  logic             advance_s;

  // Whole pipeline moves together: when the output slot is empty or being
  // drained. Bubbles are shifted like data, never squeezed out.
  always_comb begin
    advance_s = (!valid_c[N]) || OUT_READY;
  end

  assign IN_READY   = advance_s;
  assign valid_c[0] = IN_VALID;
  assign carry_c[0] = C0;
  assign acc_c[0]   = A;
  assign b_c[0]     = SUB ? ~B : B;

  for (genvar k = 0; k < N; k++) begin : g_stage
    slice_add_stage #(
      .WIDTH (WIDTH),
      .SLICE (SLICE),
      .IDX   (k)
    ) u_stage (
      .clk     (CLK),
      .rst_n   (RST_N),
      .en      (advance_s),
      .valid_i (valid_c[k]),
      .carry_i (carry_c[k]),
      .acc_i   (acc_c[k]),
      .b_i     (b_c[k]),
      .valid_o (valid_c[k+1]),
      .carry_o (carry_c[k+1]),
      .ovf_o   (ovf_c[k+1]),
      .acc_o   (acc_c[k+1]),
      .b_o     (b_c[k+1])
    );
  end

  assign OUT_VALID = valid_c[N];
  assign S         = acc_c[N];
  assign COUT      = carry_c[N];
  assign OVF       = ovf_c[N];

endmodule

// File: tb/tb_slice_pipe_adder.sv
// ---------------------------------------------------------------------------
// tb_slice_pipe_adder
// Directed bench for slice_pipe_adder: a 16/4 instance for reset, latency,
// directed sums, a stalled stream and mid-flight reset, plus a 4/4 instance
// swept over every operand combination.
// ---------------------------------------------------------------------------
module tb_slice_pipe_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  // 16-bit / 4-stage instance
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, s;
  logic        c0, sub, cout, ovf;
  // 4-bit / 1-stage instance
  logic        in_valid4, in_ready4, out_valid4, out_ready4;
  logic [3:0]  a4, b4, s4;
  logic        c04, sub4, cout4, ovf4;

  int err_cnt = 0;
  int chk_cnt = 0;

  slice_pipe_adder #(.WIDTH(16), .SLICE(4)) u_dut (
    .CLK(clk), .RST_N(rst_n),
    .IN_VALID(in_valid), .IN_READY(in_ready),
    .A(a), .B(b), .C0(c0), .SUB(sub),
    .OUT_VALID(out_valid), .OUT_READY(out_ready),
    .S(s), .COUT(cout), .OVF(ovf)
  );

  slice_pipe_adder #(.WIDTH(4), .SLICE(4)) u_dut4 (
    .CLK(clk), .RST_N(rst_n),
    .IN_VALID(in_valid4), .IN_READY(in_ready4),
    .A(a4), .B(b4), .C0(c04), .SUB(sub4),
    .OUT_VALID(out_valid4), .OUT_READY(out_ready4),
    .S(s4), .COUT(cout4), .OVF(ovf4)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {ovf, cout, s[15:0]} of a w-bit add/subtract.
  function automatic logic [17:0] ref_add(input int w, input logic [15:0] ra,
                                          input logic [15:0] rb, input logic rc,
                                          input logic rsub);
    int mask, bb, full, rs, rcout, rovf;
    mask  = (1 << w) - 1;
    bb    = rsub ? ((~int'(rb)) & mask) : int'(rb);
    full  = int'(ra) + bb + int'(rc);
    rs    = full & mask;
    rcout = (full >> w) & 1;
    rovf  = (((int'(ra) ^ bb ^ rs) >> (w - 1)) & 1) ^ rcout;
    return {rovf[0], rcout[0], rs[15:0]};
  endfunction

  // One operation with no stall: checks latency and the delivered result.
  task automatic run_one(input string tag, input logic [15:0] ra, input logic [15:0] rb,
                         input logic rc, input logic rsub, input logic [15:0] es,
                         input logic ec, input logic eo);
    int lat;
    lat = 0;
    @(posedge clk); #1;
    a = ra; b = rb; c0 = rc; sub = rsub; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check_eq({tag, "_rdy"}, 32'(in_ready), 32'd1);
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      if (out_valid) begin
        lat = c;
        break;
      end
    end
    check_eq({tag, "_lat"}, 32'(lat), 32'd4);
    check_eq({tag, "_s"}, 32'(s), 32'(es));
    check_eq({tag, "_cout"}, 32'(cout), 32'(ec));
    check_eq({tag, "_ovf"}, 32'(ovf), 32'(eo));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] sa [10];
    logic [15:0] sb [10];
    logic        sc [10];
    logic        sm [10];
    logic [17:0] exp_q [$];
    logic [17:0] prev4;
    int sent, got;

    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; a = 16'h0; b = 16'h0; c0 = 1'b0; sub = 1'b0;
    in_valid4 = 1'b0; out_ready4 = 1'b1; a4 = 4'h0; b4 = 4'h0; c04 = 1'b0; sub4 = 1'b0;

    // Reset state (OUT_READY low, yet IN_READY must be high).
    @(negedge clk);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_s", 32'(s), 32'd0);
    check_eq("rst_cout", 32'(cout), 32'd0);
    check_eq("rst_ovf", 32'(ovf), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_w4_valid", 32'(out_valid4), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed vectors, hand-computed.
    run_one("wrap",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_one("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_one("sub_neg", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_one("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_one("add_c0",  16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
    run_one("add_mix", 16'hABCD, 16'h1234, 1'b0, 1'b0, 16'hBE01, 1'b0, 1'b0);
    run_one("sub_nc",  16'h0003, 16'h0003, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);

    // Back-to-back stream with OUT_READY low in cycles 6..8.
    for (int i = 0; i < 10; i++) begin
      sa[i] = 16'($urandom);
      sb[i] = 16'($urandom);
      sc[i] = 1'($urandom);
      sm[i] = 1'($urandom);
    end
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 40 && got < 10; cyc++) begin
      @(posedge clk); #1;
      out_ready = (cyc >= 6 && cyc <= 8) ? 1'b0 : 1'b1;
      if (sent < 10) begin
        in_valid = 1'b1; a = sa[sent]; b = sb[sent]; c0 = sc[sent]; sub = sm[sent];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      check_eq("strm_in_ready", 32'(in_ready), (cyc >= 6 && cyc <= 8) ? 32'd0 : 32'd1);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("strm_extra", 32'(out_valid), 32'd0);
        end else begin
          check_eq("strm_res", 32'({ovf, cout, s}), 32'(exp_q[0]));
          if (out_ready) begin
            void'(exp_q.pop_front());
            got++;
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_add(16, a, b, c0, sub));
        sent++;
      end
    end
    check_eq("strm_count", 32'(got), 32'd10);
    in_valid = 1'b0;
    out_ready = 1'b1;

    // Mid-flight reset: three operations discarded, next result is fresh.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; a = 16'hAAAA; b = 16'h0101; c0 = 1'b0; sub = 1'b0;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("midrst_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_s", 32'(s), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_one("post_rst", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);

    // WIDTH=SLICE=4: every A, B, C0 in both modes, latency 1.
    prev4 = 18'h0;
    for (int i = 0; i <= 1024; i++) begin
      @(posedge clk); #1;
      if (i < 1024) begin
        in_valid4 = 1'b1;
        a4 = 4'(i); b4 = 4'(i >> 4); c04 = 1'(i >> 8); sub4 = 1'(i >> 9);
      end else begin
        in_valid4 = 1'b0;
      end
      @(negedge clk);
      if (i == 0) begin
        check_eq("w4_idle", 32'(out_valid4), 32'd0);
      end else begin
        check_eq("w4_res", 32'({out_valid4, ovf4, cout4, s4}),
                 32'({1'b1, prev4[17], prev4[16], prev4[3:0]}));
      end
      prev4 = ref_add(4, 16'(a4), 16'(b4), c04, sub4);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
